gps_chan_sched: RTL and testbench
=================================

// Module: gps_chan_sched
// PURPOSE
//  Sample-rate strobe generator and timed, atomic parameter loader for the N-channel GPS emulator.
//  Produces dv_out at a runtime-programmable clk divide and counts emitted samples.
//  Applies per-satellite staging parameters (code freq, Doppler, gain, C/A select) atomically.
//  Sits between the AXI register file and gps_emulator: dv_out feeds dv_in, act_* feed the channel ports.
// PARAMETERS
//  NSAT     4    number of satellite channels
//  NCOUNT   48   sample counter / commit time width
//  NDIV     16   divider width
// PORTS
//  clk            in   1          system clock
//  reset          in   1          synchronous, active-high
//  enable         in   1          run strobe generator
//  rate_div       in   NDIV       dv period = rate_div+1 clk
//  stg_code_freq  in   32 x NSAT  staging code NCO word
//  stg_dop_freq   in   32 x NSAT  staging Doppler NCO word
//  stg_gain       in   16 x NSAT  staging gain
//  stg_ca_sel     in   6 x NSAT   staging C/A select (0-35)
//  commit_req     in   1          1-clk pulse: snapshot staging, arm
//  commit_mode    in   1          0 = apply at next dv, 1 = apply at sample commit_at
//  commit_at      in   NCOUNT     target sample index (mode 1)
//  commit_abort   in   1          1-clk pulse: discard armed commit
//  status_clr     in   1          clear sticky flags
//  dv_out         out  1          sample strobe, 1 clk wide
//  sample_count   out  NCOUNT     index of next/current sample
//  act_code_freq, act_dop_freq, act_gain, act_ca_sel  out  as stg_*  active params
//  commit_pending out  1          state == ARMED
//  commit_done    out  1          1-clk pulse, coincident with dv_out of first new-param sample
//  commit_late    out  1          sticky: mode-1 target already passed when applied
//  commit_ovf     out  1          sticky: commit_req received while ARMED
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; divider counter = rate_div; pending buffer 0.
//  Divider: enable=0 -> counter reloads rate_div, dv_out=0, sample_count held.
//    enable=1 -> counter decrements; at 0, dv_out=1 next cycle and counter reloads rate_div.
//    First dv_out on the (rate_div+1)th rising edge after enable is sampled high.
//    rate_div=0 -> dv_out every clk. A rate_div change takes effect at the next reload.
//  sample_count: equals index of the sample flagged while dv_out=1; increments the edge after.
//    Wraps modulo 2^NCOUNT; commit_at compare is unsigned.
//  FSM IDLE: commit_req -> snapshot all stg_* plus mode/commit_at into pending; -> ARMED.
//  FSM ARMED, fire condition: divider about to assert dv_out AND (mode 0 OR sample_count >= commit_at).
//    On fire: act_* load pending on the same edge that raises dv_out; commit_done=1 that cycle; -> IDLE.
//    Mode 1 with sample_count > commit_at at fire -> commit_late set.
//  FSM ARMED, commit_req -> ignored, commit_ovf set (also when coincident with fire).
//  FSM ARMED, commit_abort -> IDLE, act_* unchanged; abort wins over a coincident fire.
//  enable=0 while ARMED: remains ARMED indefinitely.
//  Reset mid-operation: returns to reset values immediately.
//  status_clr clears late/ovf; a set in the same cycle wins.
//  act_* change only on fire or reset.
// CONFIGURATION
//  GPS_SCHED_CHAN_MASK_EN defined: adds input commit_mask[NSAT-1:0], snapshotted with commit_req.
//    Only masked channels load on fire; others hold.
//  Undefined: no port; all NSAT channels load on fire.
// STRUCTURE
//  gps_pkg: typedef struct chan_param_t {code_freq, dop_freq, gain, ca_sel};
//    sched_state_t enum {IDLE, ARMED}; CA_SEL_W=6.
//  Sub-module gps_dv_divider: enable, rate_div -> dv_out, dv_next (fire-qualifier), sample_count.
// TESTING
//  rate_div=63, enable 1 -> dv_out every 64 clk, first on edge 64; sample_count 0,1,2...
//  Mode 0, commit_req mid-period -> act_* update on next dv edge, commit_done with that dv_out.
//  Mode 1, commit_at=100, req at count 10 -> apply with dv_out of sample 100, late=0.
//    Same with commit_at=5 -> apply at next dv_out, late=1.
//  ARMED + second commit_req -> ovf=1, first snapshot applied.
//    abort coincident with fire -> act_* unchanged, IDLE.
//  enable dropped while ARMED, reset asserted mid-period -> all outputs 0, state IDLE.
//    With GPS_SCHED_CHAN_MASK_EN, mask=4'b0101 -> only ch0, ch2 update.

Source files
------------

// File: rtl/gps_pkg.sv
// Shared types for the GPS channel scheduler: per-channel parameter record and FSM states.
// No logic, no latency.
// No flow control; types only.
package gps_pkg;

  localparam int CA_SEL_W = 6;
  localparam int CODE_W   = 32;
  localparam int DOP_W    = 32;
  localparam int GAIN_W   = 16;

  // One satellite channel's NCO/gain/code setup, moved as a unit between staging, pending and active.
  typedef struct packed {
    logic [CODE_W-1:0]   code_freq;
    logic [DOP_W-1:0]    dop_freq;
    logic [GAIN_W-1:0]   gain;
    logic [CA_SEL_W-1:0] ca_sel;
  } chan_param_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } sched_state_t;

endpackage

// File: rtl/gps_dv_divider.sv
// Sample strobe divider: dv_out once every rate_div+1 clocks while enabled, plus running sample index.
// First strobe on the (rate_div+1)th edge after enable; dv_next flags the cycle before each strobe.
// No backpressure; dropping enable parks the divider with its counter reloaded.
module gps_dv_divider #(
  parameter int NDIV   = 16,
  parameter int NCOUNT = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NDIV-1:0]   rate_div,
  output logic              dv_out,
  output logic              dv_next,
  output logic [NCOUNT-1:0] sample_count
);

  localparam logic [NDIV-1:0]   DIV_ONE = {{(NDIV-1){1'b0}}, 1'b1};
  localparam logic [NCOUNT-1:0] CNT_ONE = {{(NCOUNT-1){1'b0}}, 1'b1};

  logic [NDIV-1:0]   r_div_cnt;
  logic              r_dv;
  logic [NCOUNT-1:0] r_sample;

  // Down-counter reloads on terminal count; the sample index advances the edge after each strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= rate_div;
      r_dv      <= 1'b0;
      r_sample  <= '0;
    end else begin
      if (r_dv) begin
        r_sample <= r_sample + CNT_ONE;
      end
      if (!enable) begin
        r_div_cnt <= rate_div;
        r_dv      <= 1'b0;
      end else if (r_div_cnt == '0) begin
        r_div_cnt <= rate_div;
        r_dv      <= 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt - DIV_ONE;
        r_dv      <= 1'b0;
      end
    end
  end

  assign dv_next      = enable && (r_div_cnt == '0);
  assign dv_out       = r_dv;
  assign sample_count = r_sample;

endmodule

// File: rtl/gps_chan_sched.sv
// Sample strobe plus atomic, optionally time-targeted loader of per-satellite channel parameters.
// act_* update on the same edge that raises dv_out for the first new-parameter sample.
// No backpressure: commit_req while armed is dropped and flagged sticky in commit_ovf.
// Optional GPS_SCHED_CHAN_MASK_EN adds commit_mask so only selected channels load on fire.
module gps_chan_sched
  import gps_pkg::*;
#(
  parameter int NSAT   = 4,
  parameter int NCOUNT = 48,
  parameter int NDIV   = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NDIV-1:0]                 rate_div,
  input  logic [NSAT-1:0][CODE_W-1:0]     stg_code_freq,
  input  logic [NSAT-1:0][DOP_W-1:0]      stg_dop_freq,
  input  logic [NSAT-1:0][GAIN_W-1:0]     stg_gain,
  input  logic [NSAT-1:0][CA_SEL_W-1:0]   stg_ca_sel,
  input  logic                            commit_req,
  input  logic                            commit_mode,
  input  logic [NCOUNT-1:0]               commit_at,
  input  logic                            commit_abort,
`ifdef GPS_SCHED_CHAN_MASK_EN
  input  logic [NSAT-1:0]                 commit_mask,
`endif
  input  logic                            status_clr,
  output logic                            dv_out,
  output logic [NCOUNT-1:0]               sample_count,
  output logic [NSAT-1:0][CODE_W-1:0]     act_code_freq,
  output logic [NSAT-1:0][DOP_W-1:0]      act_dop_freq,
  output logic [NSAT-1:0][GAIN_W-1:0]     act_gain,
  output logic [NSAT-1:0][CA_SEL_W-1:0]   act_ca_sel,
  output logic                            commit_pending,
  output logic                            commit_done,
  output logic                            commit_late,
  output logic                            commit_ovf
);

  localparam logic [NCOUNT-1:0] CNT_ONE = {{(NCOUNT-1){1'b0}}, 1'b1};

  logic                     w_dv_next;
  logic [NCOUNT-1:0]        w_next_idx;
  logic                     w_fire;
  logic [NSAT-1:0]          w_load_mask;
  chan_param_t [NSAT-1:0]   w_stg;

  sched_state_t             r_state;
  chan_param_t [NSAT-1:0]   r_pend;
  logic                     r_pend_mode;
  logic [NCOUNT-1:0]        r_pend_at;
  chan_param_t [NSAT-1:0]   r_act;
  logic                     r_done;
  logic                     r_late;
  logic                     r_ovf;

  gps_dv_divider #(
    .NDIV   (NDIV),
    .NCOUNT (NCOUNT)
  ) u_div (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .rate_div     (rate_div),
    .dv_out       (dv_out),
    .dv_next      (w_dv_next),
    .sample_count (sample_count)
  );

  // Index of the sample the upcoming strobe will flag; at rate_div=0 the current one is still on dv_out.
  assign w_next_idx = dv_out ? (sample_count + CNT_ONE) : sample_count;

  // Abort wins over a coincident fire.
  assign w_fire = (r_state == ARMED) && w_dv_next && !commit_abort &&
                  (!r_pend_mode || (w_next_idx >= r_pend_at));

`ifdef GPS_SCHED_CHAN_MASK_EN
  logic [NSAT-1:0] r_pend_mask;

  // Channel-select mask is captured together with the staging snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_mask <= '0;
    end else if ((r_state == IDLE) && commit_req) begin
      r_pend_mask <= commit_mask;
    end
  end

  assign w_load_mask = r_pend_mask;
`else
  assign w_load_mask = '1;
`endif

  // Gather the flat staging ports into per-channel records.
  always_comb begin
    w_stg = '0;
    for (int c = 0; c < NSAT; c++) begin
      w_stg[c].code_freq = stg_code_freq[c];
      w_stg[c].dop_freq  = stg_dop_freq[c];
      w_stg[c].gain      = stg_gain[c];
      w_stg[c].ca_sel    = stg_ca_sel[c];
    end
  end

  // Commit FSM: snapshot on request, apply on the qualifying strobe, abort back to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_pend_mode <= 1'b0;
      r_pend_at   <= '0;
      r_act       <= '0;
      r_done      <= 1'b0;
      r_late      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (status_clr) begin
        r_late <= 1'b0;
        r_ovf  <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (commit_req) begin
            r_pend      <= w_stg;
            r_pend_mode <= commit_mode;
            r_pend_at   <= commit_at;
            r_state     <= ARMED;
          end
        end
        ARMED: begin
          if (commit_req) begin
            r_ovf <= 1'b1;
          end
          if (commit_abort) begin
            r_state <= IDLE;
          end else if (w_fire) begin
            for (int c = 0; c < NSAT; c++) begin
              if (w_load_mask[c]) begin
                r_act[c] <= r_pend[c];
              end
            end
            r_done <= 1'b1;
            if (r_pend_mode && (w_next_idx > r_pend_at)) begin
              r_late <= 1'b1;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Spread active records back onto the flat channel ports.
  always_comb begin
    act_code_freq = '0;
    act_dop_freq  = '0;
    act_gain      = '0;
    act_ca_sel    = '0;
    for (int c = 0; c < NSAT; c++) begin
      act_code_freq[c] = r_act[c].code_freq;
      act_dop_freq[c]  = r_act[c].dop_freq;
      act_gain[c]      = r_act[c].gain;
      act_ca_sel[c]    = r_act[c].ca_sel;
    end
  end

  assign commit_pending = (r_state == ARMED);
  assign commit_done    = r_done;
  assign commit_late    = r_late;
  assign commit_ovf     = r_ovf;

endmodule

// File: tb/tb_gps_chan_sched.sv
// Directed bench for gps_chan_sched: strobe timing, commit modes, overflow, abort, enable-drop, reset.
// Expected active parameter sets are queued at commit time and popped when commit_done pulses.
// Build with GPS_SCHED_CHAN_MASK_EN to exercise the channel mask path.
module tb_gps_chan_sched;
  import gps_pkg::*;

  localparam int NSAT = 4;
  localparam int NCOUNT = 48;
  localparam int NDIV = 16;

  typedef chan_param_t [NSAT-1:0] prm_set_t;

  logic clk = 1'b0;
  logic reset, enable, commit_req, commit_mode, commit_abort, status_clr;
  logic [NDIV-1:0] rate_div;
  logic [NCOUNT-1:0] commit_at;
  logic [NSAT-1:0][31:0] stg_code_freq, stg_dop_freq, act_code_freq, act_dop_freq;
  logic [NSAT-1:0][15:0] stg_gain, act_gain;
  logic [NSAT-1:0][5:0]  stg_ca_sel, act_ca_sel;
  logic dv_out, commit_pending, commit_done, commit_late, commit_ovf;
  logic [NCOUNT-1:0] sample_count;
`ifdef GPS_SCHED_CHAN_MASK_EN
  logic [NSAT-1:0] commit_mask;
`endif

  prm_set_t stg;
  prm_set_t m_act;
  prm_set_t sb_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < NSAT; c++) begin
      stg_code_freq[c] = stg[c].code_freq;
      stg_dop_freq[c]  = stg[c].dop_freq;
      stg_gain[c]      = stg[c].gain;
      stg_ca_sel[c]    = stg[c].ca_sel;
    end
  end

  gps_chan_sched #(.NSAT(NSAT), .NCOUNT(NCOUNT), .NDIV(NDIV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rate_div(rate_div),
    .stg_code_freq(stg_code_freq), .stg_dop_freq(stg_dop_freq),
    .stg_gain(stg_gain), .stg_ca_sel(stg_ca_sel),
    .commit_req(commit_req), .commit_mode(commit_mode), .commit_at(commit_at),
    .commit_abort(commit_abort),
`ifdef GPS_SCHED_CHAN_MASK_EN
    .commit_mask(commit_mask),
`endif
    .status_clr(status_clr), .dv_out(dv_out), .sample_count(sample_count),
    .act_code_freq(act_code_freq), .act_dop_freq(act_dop_freq),
    .act_gain(act_gain), .act_ca_sel(act_ca_sel),
    .commit_pending(commit_pending), .commit_done(commit_done),
    .commit_late(commit_late), .commit_ovf(commit_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic prm_set_t mk(input int s);
    prm_set_t r;
    for (int c = 0; c < NSAT; c++) begin
      r[c].code_freq = 32'h1000_0000 + 32'(s * 256 + c);
      r[c].dop_freq  = 32'hD000_0000 ^ 32'((s << 8) + c + 7);
      r[c].gain      = 16'(s * 16 + c + 1);
      r[c].ca_sel    = 6'((s * 4 + c) % 36);
    end
    return r;
  endfunction

  task automatic check_act(input string tag, input prm_set_t e);
    for (int c = 0; c < NSAT; c++) begin
      chk($sformatf("%s_code%0d", tag, c), 64'(act_code_freq[c]), 64'(e[c].code_freq));
      chk($sformatf("%s_dop%0d", tag, c),  64'(act_dop_freq[c]),  64'(e[c].dop_freq));
      chk($sformatf("%s_gain%0d", tag, c), 64'(act_gain[c]),      64'(e[c].gain));
      chk($sformatf("%s_ca%0d", tag, c),   64'(act_ca_sel[c]),    64'(e[c].ca_sel));
    end
  endtask

  // Edges until dv_out is seen, bounded.
  task automatic wait_dv(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!dv_out && n < budget);
    chk("dv_seen", 64'(dv_out), 64'd1);
  endtask

  // Wait for commit_done, then pop the scoreboard and compare the active parameters.
  task automatic wait_done(input string tag, input int budget);
    int n;
    prm_set_t e;
    n = 0;
    do begin
      tick();
      n++;
    end while (!commit_done && n < budget);
    chk({tag, "_done_seen"}, 64'(commit_done), 64'd1);
    chk({tag, "_done_with_dv"}, 64'(dv_out), 64'd1);
    if (commit_done) begin
      chk({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        m_act = e;
        check_act({tag, "_act"}, e);
      end
    end
  endtask

  task automatic pulse_req(input prm_set_t p, input logic mode, input logic [NCOUNT-1:0] at);
    stg = p;
    commit_mode = mode;
    commit_at = at;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  initial begin
    int n;
    logic [NCOUNT-1:0] held;
    prm_set_t exp_h;

    reset = 1'b1; enable = 1'b0; rate_div = 16'd63; commit_req = 1'b0;
    commit_mode = 1'b0; commit_at = '0; commit_abort = 1'b0; status_clr = 1'b0;
    stg = '0; m_act = '0;
`ifdef GPS_SCHED_CHAN_MASK_EN
    commit_mask = '1;
`endif
    repeat (3) tick();

    // Reset state
    chk("rst_dv", 64'(dv_out), 64'd0);
    chk("rst_count", 64'(sample_count), 64'd0);
    chk("rst_pending", 64'(commit_pending), 64'd0);
    chk("rst_done", 64'(commit_done), 64'd0);
    chk("rst_late", 64'(commit_late), 64'd0);
    chk("rst_ovf", 64'(commit_ovf), 64'd0);
    check_act("rst", '0);
    reset = 1'b0;
    tick();

    // Divide-by-64: first strobe on edge 64, then every 64, sample index 0,1,2
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_dv(200, n);
      chk($sformatf("period%0d", i), 64'(n), 64'd64);
      chk($sformatf("sample%0d", i), 64'(sample_count), 64'(i));
    end

    // Switch to divide-by-4; takes effect at the next reload
    rate_div = 16'd3;
    wait_dv(100, n);
    chk("reload_old_period", 64'(n), 64'd64);
    chk("sample3", 64'(sample_count), 64'd3);
    wait_dv(10, n);
    chk("period_new", 64'(n), 64'd4);
    chk("sample4", 64'(sample_count), 64'd4);

    // Mode 0 commit mid-period
    tick();
    sb_q.push_back(mk(1));
    pulse_req(mk(1), 1'b0, '0);
    chk("m0_pending", 64'(commit_pending), 64'd1);
    check_act("m0_hold", m_act);
    wait_done("m0", 10);
    chk("m0_late", 64'(commit_late), 64'd0);
    tick();
    chk("m0_idle", 64'(commit_pending), 64'd0);
    chk("m0_done_pulse", 64'(commit_done), 64'd0);

    // Mode 1, target 100, requested at sample 10
    n = 0;
    while (sample_count != 48'd10 && n < 200) begin
      tick();
      n++;
    end
    chk("reach_10", 64'(sample_count), 64'd10);
    sb_q.push_back(mk(2));
    pulse_req(mk(2), 1'b1, 48'd100);
    check_act("m1_hold", m_act);
    wait_done("m1", 1000);
    chk("m1_sample", 64'(sample_count), 64'd100);
    chk("m1_late", 64'(commit_late), 64'd0);

    // Mode 1, target already passed -> next strobe, late
    sb_q.push_back(mk(3));
    pulse_req(mk(3), 1'b1, 48'd5);
    wait_done("late", 10);
    chk("late_set", 64'(commit_late), 64'd1);
    status_clr = 1'b1; tick(); status_clr = 1'b0;
    chk("late_clr", 64'(commit_late), 64'd0);

    // Second request while armed -> ovf, first snapshot applied
    wait_dv(10, n);
    sb_q.push_back(mk(4));
    stg = mk(4); commit_mode = 1'b0; commit_req = 1'b1;
    tick();
    stg = mk(5);
    tick();
    commit_req = 1'b0;
    chk("ovf_pending", 64'(commit_pending), 64'd1);
    chk("ovf_set", 64'(commit_ovf), 64'd1);
    wait_done("ovf", 10);
    status_clr = 1'b1; tick(); status_clr = 1'b0;
    chk("ovf_clr", 64'(commit_ovf), 64'd0);

    // Abort coincident with fire -> act unchanged, idle
    wait_dv(10, n);
    pulse_req(mk(6), 1'b0, '0);
    tick();
    tick();
    commit_abort = 1'b1;
    tick();
    commit_abort = 1'b0;
    chk("abort_dv", 64'(dv_out), 64'd1);
    chk("abort_no_done", 64'(commit_done), 64'd0);
    chk("abort_idle", 64'(commit_pending), 64'd0);
    check_act("abort", m_act);

    // Enable dropped while armed: stays armed, no strobes, count held
    stg = mk(7); commit_mode = 1'b0; commit_req = 1'b1; enable = 1'b0;
    tick();
    commit_req = 1'b0;
    tick();
    held = sample_count;
    n = 0;
    repeat (20) begin
      tick();
      if (dv_out || commit_done) n++;
    end
    chk("noen_no_strobe", 64'(n), 64'd0);
    chk("noen_pending", 64'(commit_pending), 64'd1);
    chk("noen_count_held", 64'(sample_count), 64'(held));
    check_act("noen", m_act);

    // Reset mid-period clears everything
    enable = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    m_act = '0;
    chk("mrst_dv", 64'(dv_out), 64'd0);
    chk("mrst_count", 64'(sample_count), 64'd0);
    chk("mrst_pending", 64'(commit_pending), 64'd0);
    chk("mrst_done", 64'(commit_done), 64'd0);
    chk("mrst_late", 64'(commit_late), 64'd0);
    chk("mrst_ovf", 64'(commit_ovf), 64'd0);
    check_act("mrst", m_act);
    reset = 1'b0;

    // Post-reset commit; with the mask build only ch0/ch2 load
    wait_dv(10, n);
    chk("post_rst_period", 64'(n), 64'd4);
    exp_h = mk(8);
`ifdef GPS_SCHED_CHAN_MASK_EN
    commit_mask = 4'b0101;
    exp_h[1] = '0;
    exp_h[3] = '0;
`endif
    sb_q.push_back(exp_h);
    pulse_req(mk(8), 1'b0, '0);
    wait_done("mask", 10);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
